// File: rtl/gain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gain_pkg
// Description : Shared constants and helper functions for the multi-channel
//               gain ramp. It provides the following:
//                 - the unity-gain helper
//                 - the default ramp step and fractional width
//                 - the symmetric saturation limits, derived from the sample
//                   width
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
package gain_pkg;

  localparam int unsigned DEF_DATA_W = 24;
  localparam int unsigned DEF_GAIN_W = 20;
  localparam int unsigned DEF_FRAC_W = 13;
  localparam int unsigned DEF_STEP   = 10;

  // A gain of 1.0 in Q(GAIN_W-FRAC_W).FRAC_W.
  function automatic longint unsigned unity_gain(input int unsigned frac_w);
    return 64'd1 << frac_w;
  endfunction

  // Largest positive magnitude that can be produced. The range is symmetric,
  // so the negative limit is the negation of this value.
  function automatic longint unsigned sat_pos(input int unsigned data_w);
    return (64'd1 << (data_w - 1)) - 64'd1;
  endfunction

  // Magnitude of the most-negative input sample (one beyond sat_pos).
  function automatic longint unsigned neg_full_mag(input int unsigned data_w);
    return 64'd1 << (data_w - 1);
  endfunction

  localparam longint unsigned DEF_SAT_POS  = sat_pos(DEF_DATA_W);
  localparam longint unsigned DEF_NEG_FULL = neg_full_mag(DEF_DATA_W);

endpackage : gain_pkg
`default_nettype wire

// File: rtl/gain_ch_dp.sv
`default_nettype none
// ============================================================================
// Module      : gain_ch_dp
// Description : Single-channel two-stage gain datapath.
//               Stage 1 registers the sign of the input sample. It also
//               registers the product |x| * gain.
//               Stage 2 does the following:
//                 - truncates the product by FRAC_W
//                 - saturates the result symmetrically
//                 - restores the sign
//                 - applies mute
//               Both stages hold their contents when their enable is low.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               s1_en_i       - load stage 1 (frame accepted this cycle)
//               s2_en_i       - load stage 2 (stage 1 holds a valid frame)
//               sample_i      - signed input sample
//               gain_i        - unsigned gain used for this sample
//               mute_i        - forces the stage-2 result to zero
//               sample_o      - scaled, saturated, signed sample
//               clip_o        - saturation flag aligned with sample_o
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module gain_ch_dp
  import gain_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned GAIN_W = DEF_GAIN_W,
  parameter int unsigned FRAC_W = DEF_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s1_en_i,
  input  logic              s2_en_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic [GAIN_W-1:0] gain_i,
  input  logic              mute_i,
  output logic [DATA_W-1:0] sample_o,
  output logic              clip_o
);

  localparam int unsigned PROD_W = DATA_W + GAIN_W;
  localparam int unsigned Q_W    = PROD_W - FRAC_W;

  localparam logic [Q_W-1:0]    Q_MAX   = Q_W'(sat_pos(DATA_W));
  localparam logic [DATA_W-1:0] OUT_MAX = DATA_W'(sat_pos(DATA_W));

  // ---------------------------------------------------------------- stage 1
  logic [DATA_W-1:0] mag_d;
  logic [PROD_W-1:0] prod_d;
  logic [PROD_W-1:0] prod_q;
  logic              sign_q;

  // The magnitude is unsigned DATA_W bits wide. The most-negative sample
  // therefore maps exactly onto 2**(DATA_W-1) without overflow.
  assign mag_d  = sample_i[DATA_W-1] ? (-sample_i) : sample_i;
  assign prod_d = PROD_W'(mag_d) * PROD_W'(gain_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
      prod_q <= '0;
    end else if (s1_en_i) begin
      sign_q <= sample_i[DATA_W-1];
      prod_q <= prod_d;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [Q_W-1:0]    q_d;
  logic              sat_d;
  logic [DATA_W-1:0] mag_sat_d;
  logic [DATA_W-1:0] out_d;
  logic              clip_d;
  logic [DATA_W-1:0] out_q;
  logic              clip_q;

  // Truncating the magnitude rounds toward zero for both signs.
  assign q_d = prod_q[PROD_W-1:FRAC_W];

  always_comb begin
    sat_d     = (q_d > Q_MAX);
    mag_sat_d = sat_d ? OUT_MAX : q_d[DATA_W-1:0];
    out_d     = '0;
    clip_d    = 1'b0;
    if (!mute_i) begin
      // A zero magnitude negates to zero, so a negative sign can never
      // produce -0.
      out_d  = sign_q ? (-mag_sat_d) : mag_sat_d;
      clip_d = sat_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      clip_q <= 1'b0;
    end else if (s2_en_i) begin
      out_q  <= out_d;
      clip_q <= clip_d;
    end
  end

  assign sample_o = out_q;
  assign clip_o   = clip_q;

endmodule : gain_ch_dp
`default_nettype wire

// File: rtl/gain_ramp_mc.sv
`default_nettype none
// ============================================================================
// Module      : gain_ramp_mc
// Description : Multi-channel audio gain stage with per-frame gain ramping.
//               Each channel has a current-gain register. On every accepted
//               frame, the register moves toward its target by up to STEP,
//               or it snaps to the target when ramping is disabled. Each
//               frame is scaled by the current gain as it stood before that
//               frame's update. A fixed two-register valid pipeline follows
//               the per-channel datapaths.
// Ports       : clk, rst   - sample clock, asynchronous active-high reset
//               in_valid   - frame strobe
//               in_data    - CH packed signed samples
//               gain_tgt   - CH packed unsigned target gains
//               ramp_en    - 1: ramp by STEP per frame, 0: snap to target
//               mute       - zero all outputs (sampled at stage 2)
//               out_valid  - output frame strobe
//               out_data   - CH packed scaled, saturated samples
//               clip       - per-channel saturation flag
//               ramp_busy  - per-channel current gain != target gain
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module gain_ramp_mc
  import gain_pkg::*;
#(
  parameter int unsigned CH       = 2,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned GAIN_W   = DEF_GAIN_W,
  parameter int unsigned FRAC_W   = DEF_FRAC_W,
  parameter int unsigned STEP     = DEF_STEP,
  parameter int unsigned GAIN_RST = 32'(unity_gain(DEF_FRAC_W))
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [CH*DATA_W-1:0] in_data,
  input  logic [CH*GAIN_W-1:0] gain_tgt,
  input  logic                 ramp_en,
  input  logic                 mute,
  output logic                 out_valid,
  output logic [CH*DATA_W-1:0] out_data,
  output logic [CH-1:0]        clip,
  output logic [CH-1:0]        ramp_busy
);

  localparam logic [GAIN_W-1:0] STEP_G  = GAIN_W'(STEP);
  localparam logic [GAIN_W-1:0] RESET_G = GAIN_W'(GAIN_RST);

  // -------------------------------------------------------- valid pipeline
  logic v1_q;
  logic v2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= in_valid;
      v2_q <= v1_q;
    end
  end

  assign out_valid = v2_q;

  // ------------------------------------------------ per-channel ramp + path
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [GAIN_W-1:0] tgt;
    logic [GAIN_W-1:0] cur_q;
    logic [GAIN_W-1:0] cur_d;

    assign tgt = gain_tgt[c*GAIN_W +: GAIN_W];

    // Each difference is taken only in the direction where it is
    // non-negative, so the unsigned arithmetic never wraps.
    always_comb begin
      cur_d = cur_q;
      if (!ramp_en) begin
        cur_d = tgt;
      end else if (cur_q > tgt) begin
        cur_d = ((cur_q - tgt) >= STEP_G) ? (cur_q - STEP_G) : tgt;
      end else if (cur_q < tgt) begin
        cur_d = ((tgt - cur_q) >= STEP_G) ? (cur_q + STEP_G) : tgt;
      end
    end

    // The gain advances only on accepted frames. This makes the ramp rate
    // track the sample rate rather than the clock rate.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cur_q <= RESET_G;
      end else if (in_valid) begin
        cur_q <= cur_d;
      end
    end

    assign ramp_busy[c] = (cur_q != tgt);

    gain_ch_dp #(
      .DATA_W (DATA_W),
      .GAIN_W (GAIN_W),
      .FRAC_W (FRAC_W)
    ) u_dp (
      .clk      (clk),
      .rst      (rst),
      .s1_en_i  (in_valid),
      .s2_en_i  (v1_q),
      .sample_i (in_data[c*DATA_W +: DATA_W]),
      .gain_i   (cur_q),
      .mute_i   (mute),
      .sample_o (out_data[c*DATA_W +: DATA_W]),
      .clip_o   (clip[c])
    );
  end

endmodule : gain_ramp_mc
`default_nettype wire

// File: tb/tb_gain_ramp_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_gain_ramp_mc
// Description : Directed self-checking bench for gain_ramp_mc (CH=2, 24-bit
//               samples, 20-bit gain with 13 fractional bits, STEP=10).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gain_ramp_mc;

  localparam int CH = 2;
  localparam int DW = 24;
  localparam int GW = 20;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [CH*DW-1:0]   in_data;
  logic [CH*GW-1:0]   gain_tgt;
  logic               ramp_en;
  logic               mute;
  logic               out_valid;
  logic [CH*DW-1:0]   out_data;
  logic [CH-1:0]      clip;
  logic [CH-1:0]      ramp_busy;

  int n_checks = 0;
  int n_fail   = 0;

  gain_ramp_mc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .gain_tgt  (gain_tgt),
    .ramp_en   (ramp_en),
    .mute      (mute),
    .out_valid (out_valid),
    .out_data  (out_data),
    .clip      (clip),
    .ramp_busy (ramp_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [DW-1:0] d0,
                           input logic [DW-1:0] d1, input logic [CH-1:0] c);
    check({tag, "_valid"}, 64'(out_valid), 64'(v));
    check({tag, "_ch0"}, 64'(out_data[DW-1:0]), 64'(d0));
    check({tag, "_ch1"}, 64'(out_data[2*DW-1:DW]), 64'(d1));
    check({tag, "_clip"}, 64'(clip), 64'(c));
  endtask

  task automatic set_tgt(input int g0, input int g1);
    gain_tgt = {GW'(g1), GW'(g0)};
  endtask

  // Single isolated frame: accept on the first edge, result after the second.
  task automatic send(input string tag, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    in_valid = 1'b1;
    in_data  = {d1, d0};
    step();
    in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(out_valid), 64'd0);
    step();
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    ramp_en  = 1'b0;
    mute     = 1'b0;
    set_tgt(8192, 16384);
    step();
    step();
    // Reset state: cur gains are 8192, so only channel 1 is busy.
    check_out("rst", 1'b0, 24'h0, 24'h0, 2'b00);
    check("rst_busy", 64'(ramp_busy), 64'b10);
    set_tgt(8192, 8192);
    #1;
    check("rst_busy_unity", 64'(ramp_busy), 64'b00);
    rst = 1'b0;
    step();

    // 1. Unity gain, two-cycle latency, hold when idle
    send("t1", 24'h0003E8, 24'h0003E8);
    check_out("t1", 1'b1, 24'h0003E8, 24'h0003E8, 2'b00);
    step();
    check_out("t1_hold", 1'b0, 24'h0003E8, 24'h0003E8, 2'b00);

    // 2. Gain x2: negative product and positive saturation
    set_tgt(16384, 16384);
    send("t2_snap", 24'h0, 24'h0);
    send("t2", 24'hFFFC18, 24'h600000);
    check_out("t2", 1'b1, 24'hFFF830, 24'h7FFFFF, 2'b10);

    // 3. Most-negative input saturates to the symmetric limit
    set_tgt(8192, 8192);
    send("t3_snap", 24'h0, 24'h0);
    send("t3", 24'h800000, 24'h000001);
    check_out("t3", 1'b1, 24'h800001, 24'h000001, 2'b01);

    // 4. Ramp: input 0x2000 makes the output equal the gain used
    ramp_en = 1'b1;
    set_tgt(8222, 8192);
    #1;
    check("t4_busy0", 64'(ramp_busy), 64'b01);
    send("t4a", 24'h2000, 24'h2000);
    check_out("t4a", 1'b1, 24'h002000, 24'h002000, 2'b00);
    check("t4a_busy", 64'(ramp_busy), 64'b01);
    send("t4b", 24'h2000, 24'h2000);
    check_out("t4b", 1'b1, 24'h00200A, 24'h002000, 2'b00);
    send("t4c", 24'h2000, 24'h2000);
    check_out("t4c", 1'b1, 24'h002014, 24'h002000, 2'b00);
    check("t4c_busy", 64'(ramp_busy), 64'b00);
    send("t4d", 24'h2000, 24'h2000);
    check_out("t4d", 1'b1, 24'h00201E, 24'h002000, 2'b00);
    set_tgt(8225, 8180);
    step();
    step();
    check("t4_idle_busy", 64'(ramp_busy), 64'b11);
    send("t4e", 24'h2000, 24'h2000);
    check_out("t4e", 1'b1, 24'h00201E, 24'h002000, 2'b00);
    check("t4e_busy", 64'(ramp_busy), 64'b10);
    send("t4f", 24'h2000, 24'h2000);
    check_out("t4f", 1'b1, 24'h002021, 24'h001FF6, 2'b00);
    check("t4f_busy", 64'(ramp_busy), 64'b00);
    // Truncation toward zero on negative samples (gains 8225 / 8180)
    send("t4g", 24'hFFFFFF, 24'hFFFFFD);
    check_out("t4g", 1'b1, 24'hFFFFFF, 24'hFFFFFE, 2'b00);
    send("t4h", 24'h000000, 24'hFFFFFF);
    check_out("t4h", 1'b1, 24'h000000, 24'h000000, 2'b00);

    // 5. Back-to-back frames with the middle one muted at stage 2
    ramp_en = 1'b0;
    set_tgt(8192, 16384);
    send("t5_snap", 24'h0, 24'h0);
    in_valid = 1'b1;
    in_data  = {24'h000100, 24'h000100};
    step();
    in_data  = {24'h600000, 24'h000200};
    check("t5_lat1", 64'(out_valid), 64'd0);
    step();
    check_out("t5a", 1'b1, 24'h000100, 24'h000200, 2'b00);
    mute     = 1'b1;
    in_data  = {24'hFFFD00, 24'h000300};
    step();
    in_valid = 1'b0;
    mute     = 1'b0;
    check_out("t5b_mute", 1'b1, 24'h000000, 24'h000000, 2'b00);
    step();
    check_out("t5c", 1'b1, 24'h000300, 24'hFFFA00, 2'b00);
    step();
    check("t5_end", 64'(out_valid), 64'd0);

    // 6. Reset while a frame is in flight
    set_tgt(16384, 16384);
    in_valid = 1'b1;
    in_data  = {24'h000100, 24'h000100};
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_out("t6_rst", 1'b0, 24'h0, 24'h0, 2'b00);
    check("t6_rst_busy", 64'(ramp_busy), 64'b11);
    step();
    rst = 1'b0;
    step();
    check("t6_nov1", 64'(out_valid), 64'd0);
    step();
    check("t6_nov2", 64'(out_valid), 64'd0);
    send("t6a", 24'h000100, 24'h000100);
    check_out("t6a", 1'b1, 24'h000100, 24'h000100, 2'b00);
    check("t6a_busy", 64'(ramp_busy), 64'b00);
    send("t6b", 24'h000100, 24'h000100);
    check_out("t6b", 1'b1, 24'h000200, 24'h000200, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gain_ramp_mc
`default_nettype wire
